// File: rtl/xor_fault_sequencer.sv
// Laser fault-injection sequencer for a WIDTH-input XOR target: steps a_out, fires a laser window, checks q against parity.
// Optional build macro XOR_SEQ_STOP_ON_FAULT_EN ends the run at the first faulted vector.
module xor_fault_sequencer #(
    parameter int WIDTH         = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vecs,
    output logic [WIDTH-1:0] a_out,
    input  logic             q_in,
    output logic             laser_trig,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] fault_vec,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] fault_count,
    output logic [2:0]       state_dbg
);
    // start is a one-cycle request with no ready: it is accepted only in IDLE or DONE, dropped otherwise.
    typedef enum logic [2:0] {IDLE, APPLY, FIRE, SAMPLE, RESULT, DONE} state_t;

    localparam int PH_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t           state;
    logic [PH_W-1:0]  phase_cnt;
    logic [CNT_W-1:0] num_vecs_q;
    logic             q_meta;
    logic             q_sync;
    logic             exp_q;
    logic             mismatch;
    logic             last_vec;
    logic             stop_run;

    assign state_dbg = state;
    assign last_vec  = (vec_count + CNT_W'(1)) == num_vecs_q;

`ifdef XOR_SEQ_STOP_ON_FAULT_EN
    assign stop_run = last_vec || mismatch;
`else
    assign stop_run = last_vec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            num_vecs_q  <= '0;
            q_meta      <= 1'b0;
            q_sync      <= 1'b0;
            exp_q       <= 1'b0;
            mismatch    <= 1'b0;
            a_out       <= '0;
            laser_trig  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_vec   <= '0;
            vec_count   <= '0;
            fault_count <= '0;
        end else begin
            q_meta <= q_in;
            q_sync <= q_meta;
            fault  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_vecs_q  <= num_vecs;
                        vec_count   <= '0;
                        fault_count <= '0;
                        a_out       <= '0;
                        exp_q       <= 1'b0;
                        mismatch    <= 1'b0;
                        phase_cnt   <= '0;
                        if (num_vecs == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= APPLY;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                APPLY: begin
                    if (phase_cnt == PH_W'(SETTLE_CYCLES - 1)) begin
                        phase_cnt  <= '0;
                        laser_trig <= 1'b1;
                        state      <= FIRE;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                FIRE: begin
                    mismatch <= mismatch | (q_sync != exp_q);
                    if (phase_cnt == PH_W'(HOLD_CYCLES - 1)) begin
                        phase_cnt  <= '0;
                        laser_trig <= 1'b0;
                        state      <= SAMPLE;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                SAMPLE: begin
                    // Two cycles let the last laser-window response clear the synchronizer.
                    mismatch <= mismatch | (q_sync != exp_q);
                    if (phase_cnt == PH_W'(1)) begin
                        phase_cnt <= '0;
                        state     <= RESULT;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                RESULT: begin
                    vec_count <= vec_count + CNT_W'(1);
                    if (mismatch) begin
                        fault     <= 1'b1;
                        fault_vec <= a_out;
                        if (fault_count != {CNT_W{1'b1}})
                            fault_count <= fault_count + CNT_W'(1);
                    end
                    if (stop_run) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        a_out    <= a_out + WIDTH'(1);
                        exp_q    <= ^(a_out + WIDTH'(1));
                        mismatch <= 1'b0;
                        state    <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_fault_sequencer.sv
// Randomized bench for xor_fault_sequencer: a vector-level model predicts laser pulses, faults and final counters.
// Honours XOR_SEQ_STOP_ON_FAULT_EN when the design is built with it.
module tb_xor_fault_sequencer;
    localparam int WIDTH  = 6;
    localparam int SETTLE = 4;
    localparam int HOLD   = 8;
    localparam int CNT_W  = 16;
    localparam int PER_VEC = SETTLE + HOLD + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vecs = '0;
    logic [WIDTH-1:0] a_out;
    logic             q_in;
    logic             laser_trig, busy, done, fault;
    logic [WIDTH-1:0] fault_vec;
    logic [CNT_W-1:0] vec_count, fault_count;
    logic [2:0]       state_dbg;

    logic             inj_en = 1'b0;
    logic [WIDTH-1:0] inj_val = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] last_fault_vec = '0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_fault_q[$];
    logic [WIDTH-1:0] obs_vec_q[$];
    logic [WIDTH-1:0] obs_fault_q[$];
    int               obs_width_q[$];

    // Target model: a correct XOR, inverted only on the injected vector.
    assign q_in = (^a_out) ^ (inj_en && (a_out == inj_val));

    xor_fault_sequencer #(
        .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs), .a_out(a_out),
        .q_in(q_in), .laser_trig(laser_trig), .busy(busy), .done(done), .fault(fault),
        .fault_vec(fault_vec), .vec_count(vec_count), .fault_count(fault_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Monitor: records each laser pulse (a_out at rise, width) and each fault pulse.
    initial begin
        logic prev;
        int   hi;
        prev = 1'b0;
        hi   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                hi   = 0;
            end else begin
                if (laser_trig && !prev) obs_vec_q.push_back(a_out);
                if (laser_trig) hi++;
                if (!laser_trig && prev) begin
                    obs_width_q.push_back(hi);
                    hi = 0;
                end
                if (fault) obs_fault_q.push_back(fault_vec);
                prev = laser_trig;
            end
        end
    end

    task automatic run_vectors(input int n, input logic en, input logic [WIDTH-1:0] bad);
        int vc, fc, lat, exp_lat, budget;
        logic [WIDTH-1:0] v;
        exp_q.delete();
        exp_fault_q.delete();
        obs_vec_q.delete();
        obs_fault_q.delete();
        obs_width_q.delete();
        vc = 0;
        fc = 0;
        for (int i = 0; i < n; i++) begin
            v = WIDTH'(i % (1 << WIDTH));
            exp_q.push_back(v);
            vc++;
            if (en && v == bad) begin
                exp_fault_q.push_back(v);
                fc++;
                last_fault_vec = v;
`ifdef XOR_SEQ_STOP_ON_FAULT_EN
                break;
`endif
            end
        end
        exp_lat = PER_VEC * vc;
        budget  = exp_lat + 50;

        @(negedge clk);
        inj_en   = en;
        inj_val  = bad;
        num_vecs = CNT_W'(n);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, {31'b0, (n != 0)});
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
            // A start during the run must be ignored.
            if (lat == 20 && exp_lat > 25) begin
                num_vecs = CNT_W'($urandom_range(1, 9));
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_latency", lat, exp_lat);
        check("done", {31'b0, done}, 32'd1);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        check("vec_count", {16'b0, vec_count}, vc);
        check("fault_count", {16'b0, fault_count}, fc);
        check("fault_vec", {26'b0, fault_vec}, {26'b0, last_fault_vec});
        check("final_a_out", {26'b0, a_out}, (vc == 0) ? 0 : ((vc - 1) % (1 << WIDTH)));
        check("pulse_count", obs_vec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_vec_q.size(); i++)
            check("pulse_vec", {26'b0, obs_vec_q[i]}, {26'b0, exp_q[i]});
        for (int i = 0; i < obs_width_q.size(); i++)
            check("pulse_width", obs_width_q[i], HOLD);
        check("fault_pulses", obs_fault_q.size(), exp_fault_q.size());
        for (int i = 0; i < exp_fault_q.size() && i < obs_fault_q.size(); i++)
            check("fault_pulse_vec", {26'b0, obs_fault_q[i]}, {26'b0, exp_fault_q[i]});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_a_out", {26'b0, a_out}, 0);
        check("rst_outputs", {28'b0, laser_trig, busy, done, fault}, 0);
        check("rst_counts", {vec_count, fault_count}, 0);
        check("rst_fault_vec", {26'b0, fault_vec}, 0);
        rst = 1'b0;

        // Abort in the middle of the laser window.
        @(negedge clk);
        num_vecs = 16'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 2) @(negedge clk);
        check("pre_abort_laser", {31'b0, laser_trig}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_instant", {26'b0, laser_trig, busy, a_out}, 0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold", {26'b0, laser_trig, busy, a_out}, 0);
        end
        rst = 1'b0;
        last_fault_vec = '0;

        run_vectors(4, 1'b0, '0);
        run_vectors(64, 1'b1, 6'h2A);
        run_vectors(70, 1'b0, '0);
        run_vectors(0, 1'b0, '0);
        run_vectors(20, 1'b1, 6'd5);
        for (int r = 0; r < 6; r++)
            run_vectors($urandom_range(1, 80), 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 63)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
